// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter for two byte streams feeding one 8N1 UART transmitter.
// Define UART_ARB_TIMEOUT_EN to drop a stalled packet lock after TIMEOUT idle cycles.
module uart_tx_arbiter #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_valid,
  input  logic [7:0] a_data,
  input  logic       a_last,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [7:0] b_data,
  input  logic       b_last,
  output logic       b_ready,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout,
  output logic       tx
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("CLKS_PER_BIT must be at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);

  typedef enum logic {ArbIdle, ArbOwned} arb_e;
  typedef enum logic [1:0] {SIdle, SStart, SData, SStop} ser_e;

  arb_e             arb_q, arb_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_grant_q, last_grant_d;  // 0 = A, 1 = B
  ser_e             ser_q, ser_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_q, bit_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic             timeout_q;
  logic             timeout_hit;
  logic             accept, accept_last, baud_done;
  logic [7:0]       accept_data;

  assign accept      = (a_valid & a_ready) | (b_valid & b_ready);
  assign accept_data = grant_q[1] ? b_data : a_data;
  assign accept_last = grant_q[1] ? b_last : a_last;
  assign baud_done   = (baud_q == BaudMax);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT + 1);
  logic [ToW-1:0] idle_cnt_q, idle_cnt_d;
  logic           owner_valid;

  assign owner_valid = grant_q[1] ? b_valid : a_valid;

  always_comb begin
    idle_cnt_d  = idle_cnt_q;
    timeout_hit = 1'b0;
    if (arb_q != ArbOwned || owner_valid) begin
      idle_cnt_d = '0;
    end else if (ser_q == SIdle) begin
      if (idle_cnt_q == ToW'(TIMEOUT - 1)) begin
        timeout_hit = 1'b1;
        idle_cnt_d  = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + ToW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) idle_cnt_q <= '0;
    else       idle_cnt_q <= idle_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      arb_q        <= ArbIdle;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      timeout_q    <= 1'b0;
      ser_q        <= SIdle;
      shift_q      <= '0;
      bit_q        <= '0;
      baud_q       <= '0;
    end else begin
      arb_q        <= arb_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      timeout_q    <= timeout_hit;
      ser_q        <= ser_d;
      shift_q      <= shift_d;
      bit_q        <= bit_d;
      baud_q       <= baud_d;
    end
  end

  // Arbiter next state: a tie goes to whoever did not own the previous packet
  always_comb begin
    arb_d        = arb_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    unique case (arb_q)
      ArbIdle: begin
        if (a_valid || b_valid) begin
          arb_d = ArbOwned;
          if (a_valid && (!b_valid || last_grant_q)) begin
            grant_d      = 2'b01;
            last_grant_d = 1'b0;
          end else begin
            grant_d      = 2'b10;
            last_grant_d = 1'b1;
          end
        end
      end
      ArbOwned: begin
        if ((accept && accept_last) || timeout_hit) begin
          arb_d   = ArbIdle;
          grant_d = 2'b00;
        end
      end
    endcase
  end

  // Serializer next state
  always_comb begin
    ser_d   = ser_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    if (ser_q != SIdle) baud_d = baud_done ? '0 : baud_q + BaudW'(1);
    unique case (ser_q)
      SIdle: begin
        if (accept) begin
          ser_d   = SStart;
          shift_d = accept_data;
          bit_d   = '0;
          baud_d  = '0;
        end
      end
      SStart: if (baud_done) ser_d = SData;
      SData: begin
        if (baud_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) ser_d = SStop;
          else               bit_d = bit_q + 3'd1;
        end
      end
      SStop: if (baud_done) ser_d = SIdle;
    endcase
  end

  // Outputs
  always_comb begin
    a_ready = !reset && arb_q == ArbOwned && grant_q[0] && ser_q == SIdle;
    b_ready = !reset && arb_q == ArbOwned && grant_q[1] && ser_q == SIdle;
    grant   = grant_q;
    busy    = (ser_q != SIdle);
    timeout = timeout_q;
    tx      = 1'b1;
    unique case (ser_q)
      SIdle:  tx = 1'b1;
      SStart: tx = 1'b0;
      SData:  tx = shift_q[0];
      SStop:  tx = 1'b1;
    endcase
  end

endmodule
